// File: rtl/input_conditioner_pkg.sv
// Shared defaults and elaboration-time helpers for the input conditioner.
// Channel outputs are bundled so the top can fan them out per bit.
package input_conditioner_pkg;

    localparam int DEF_N_CH          = 32'sd4;
    localparam int DEF_SYNC_STAGES   = 32'sd2;
    localparam int DEF_DB_CYCLES     = 32'sd16;
    localparam int DEF_REPEAT_DELAY  = 32'sd8;
    localparam int DEF_REPEAT_PERIOD = 32'sd3;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
        logic press;
    } ch_out_t;

    // Bits needed to hold 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = 32'sd1;
        for (int i = 32'sd1; i < 32'sd31; i++) begin
            if ((32'sd1 << i) < value) begin
                w = i + 32'sd1;
            end
        end
        return w;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/input_conditioner_ch.sv
// One conditioned input: polarity, synchroniser, tick-gated debounce,
// registered edge pulses and optional auto-repeat on the press output.
module input_conditioner_ch
    import input_conditioner_pkg::*;
#(
    parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int   DB_CYCLES     = DEF_DB_CYCLES,
    parameter int   REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int   REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter logic INVERT        = 1'b0,
    parameter logic REPEAT_EN     = 1'b0
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    raw,
    input  logic    tick,
    output ch_out_t ch_out
);

    localparam int DB_W  = clog2_min1(DB_CYCLES);
    localparam int RPT_W = clog2_min1(max_int(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DB_CYCLES - 32'sd1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 32'sd1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 32'sd1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   d_s;
    logic                   s_s;
    logic                   level_r, rise_r, fall_r, press_r;
    logic [DB_W-1:0]        db_cnt_r, db_cnt_nxt_s;
    logic                   level_nxt_s, lvl_chg_s, rise_s, fall_s;
    logic [RPT_W-1:0]       rpt_cnt_r, rpt_cnt_nxt_s, rpt_last_s;
    logic                   first_r, first_nxt_s, rpt_fire_s, press_s;

    assign d_s = raw ^ INVERT;
    assign s_s = sync_r[SYNC_STAGES-1];

    // Synchroniser shift chain for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], d_s};
        end
    end

    // Debounce: a differing input must survive DB_CYCLES ticks; any bounce restarts.
    always_comb begin
        db_cnt_nxt_s = db_cnt_r;
        level_nxt_s  = level_r;
        lvl_chg_s    = 1'b0;
        if (s_s == level_r) begin
            db_cnt_nxt_s = '0;
        end else if (tick) begin
            if (db_cnt_r == DB_LAST) begin
                level_nxt_s  = s_s;
                db_cnt_nxt_s = '0;
                lvl_chg_s    = 1'b1;
            end else begin
                db_cnt_nxt_s = db_cnt_r + DB_W'(1'b1);
            end
        end else begin
            db_cnt_nxt_s = db_cnt_r;
        end
        rise_s = lvl_chg_s & s_s;
        fall_s = lvl_chg_s & ~s_s;
    end

    // Auto-repeat: long first delay, then the shorter period, only while held.
    always_comb begin
        rpt_cnt_nxt_s = rpt_cnt_r;
        first_nxt_s   = first_r;
        rpt_fire_s    = 1'b0;
        rpt_last_s    = first_r ? DELAY_LAST : PERIOD_LAST;
        if (REPEAT_EN == 1'b0) begin
            rpt_cnt_nxt_s = '0;
            first_nxt_s   = 1'b0;
        end else if (rise_s) begin
            rpt_cnt_nxt_s = '0;
            first_nxt_s   = 1'b1;
        end else if (level_r == 1'b0) begin
            rpt_cnt_nxt_s = '0;
            first_nxt_s   = 1'b0;
        end else if (tick) begin
            if (rpt_cnt_r == rpt_last_s) begin
                rpt_fire_s    = 1'b1;
                rpt_cnt_nxt_s = '0;
                first_nxt_s   = 1'b0;
            end else begin
                rpt_cnt_nxt_s = rpt_cnt_r + RPT_W'(1'b1);
            end
        end else begin
            rpt_cnt_nxt_s = rpt_cnt_r;
        end
        // A repeat coinciding with release would land after level drops; drop it.
        press_s = rise_s | (rpt_fire_s & ~fall_s);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_r   <= 1'b0;
            rise_r    <= 1'b0;
            fall_r    <= 1'b0;
            press_r   <= 1'b0;
            db_cnt_r  <= '0;
            rpt_cnt_r <= '0;
            first_r   <= 1'b0;
        end else begin
            level_r   <= level_nxt_s;
            rise_r    <= rise_s;
            fall_r    <= fall_s;
            press_r   <= press_s;
            db_cnt_r  <= db_cnt_nxt_s;
            rpt_cnt_r <= rpt_cnt_nxt_s;
            first_r   <= first_nxt_s;
        end
    end

    assign ch_out.level = level_r;
    assign ch_out.rise  = rise_r;
    assign ch_out.fall  = fall_r;
    assign ch_out.press = press_r;

endmodule

// File: rtl/input_conditioner.sv
// N-channel push-button/switch front end; each channel is independent and
// takes its polarity and repeat enable from the corresponding mask bit.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int              N_CH          = DEF_N_CH,
    parameter int              SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int              DB_CYCLES     = DEF_DB_CYCLES,
    parameter logic [N_CH-1:0] INVERT_MASK   = '0,
    parameter logic [N_CH-1:0] REPEAT_MASK   = '0,
    parameter int              REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int              REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] raw_in,
    input  logic            tick,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] press
);

    ch_out_t ch_out_s [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        input_conditioner_ch #(
            .SYNC_STAGES   (SYNC_STAGES),
            .DB_CYCLES     (DB_CYCLES),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .INVERT        (INVERT_MASK[i]),
            .REPEAT_EN     (REPEAT_MASK[i])
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .raw    (raw_in[i]),
            .tick   (tick),
            .ch_out (ch_out_s[i])
        );

        assign level[i] = ch_out_s[i].level;
        assign rise[i]  = ch_out_s[i].rise;
        assign fall[i]  = ch_out_s[i].fall;
        assign press[i] = ch_out_s[i].press;
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: 4 channels, DB_CYCLES=4, channel 2
// auto-repeats, channel 3 inverted (idles high on the pin).
module tb_input_conditioner;

    logic       clk;
    logic       reset;
    logic [3:0] raw_in;
    logic       tick;
    logic [3:0] level, rise, fall, press;

    int n_asserts = 0;
    int n_fail    = 0;

    input_conditioner #(
        .N_CH          (4),
        .SYNC_STAGES   (2),
        .DB_CYCLES     (4),
        .INVERT_MASK   (4'b1000),
        .REPEAT_MASK   (4'b0100),
        .REPEAT_DELAY  (8),
        .REPEAT_PERIOD (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .raw_in (raw_in),
        .tick   (tick),
        .level  (level),
        .rise   (rise),
        .fall   (fall),
        .press  (press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    initial begin
        logic [4:0] pat;
        logic       exp_p2;

        // Scenario 1: reset with channel 0 pressed, channel 3 idle (pin high)
        reset  = 1'b1;
        raw_in = 4'b1001;
        tick   = 1'b1;
        step(); step(); step();
        check("rst_level", level, 4'b0000);
        check("rst_rise",  rise,  4'b0000);
        check("rst_fall",  fall,  4'b0000);
        check("rst_press", press, 4'b0000);
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("s1_level_wait", level, 4'b0000);
        end
        step();
        check("s1_level", level, 4'b0001);
        check("s1_rise",  rise,  4'b0001);
        check("s1_press", press, 4'b0001);
        check("s1_fall",  fall,  4'b0000);
        // Channel 0 held with repeat off: no further press pulses
        for (int k = 1; k <= 20; k++) begin
            step();
            check("s4_hold_press", press, 4'b0000);
            check("s4_hold_rise",  rise,  4'b0000);
        end

        // Scenario 2: channel 1 bounces 1,1,1,0,1 then holds 1
        pat = 5'b10111;
        for (int k = 0; k < 5; k++) begin
            raw_in[1] = pat[k];
            step();
            check("s2_bounce_level", level, 4'b0001);
        end
        for (int k = 6; k <= 9; k++) begin
            step();
            check("s2_settle_level", level, 4'b0001);
        end
        step();
        check("s2_level", level, 4'b0011);
        check("s2_rise",  rise,  4'b0010);
        check("s2_press", press, 4'b0010);
        step();
        check("s2_rise_once", rise, 4'b0000);

        // Scenario 3: hold channel 2 for 30 cycles; rise at k=6, repeats 14,17,..,35
        raw_in[2] = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            step();
            exp_p2 = (k == 6) || (k >= 14 && k <= 35 && ((k - 14) % 3) == 0);
            check("s3_press", press, {1'b0, exp_p2, 2'b00});
            check("s3_rise",  rise,  {1'b0, (k == 6), 2'b00});
            check("s3_fall",  fall,  {1'b0, (k == 36), 2'b00});
            check("s3_level", level, {1'b0, (k >= 6 && k <= 35), 2'b11});
            if (k == 30) raw_in[2] = 1'b0;
        end

        // Scenario 6: reset during the repeat train with inputs still held
        raw_in[2] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 6)  check("s6_rise_pre", rise, 4'b0100);
        end
        check("s6_press_pre", press, 4'b0100);
        reset = 1'b1;
        step();
        check("s6_rst_level", level, 4'b0000);
        check("s6_rst_rise",  rise,  4'b0000);
        check("s6_rst_fall",  fall,  4'b0000);
        check("s6_rst_press", press, 4'b0000);
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("s6_level_wait", level, 4'b0000);
        end
        step();
        check("s6_level", level, 4'b0111);
        check("s6_rise",  rise,  4'b0111);
        check("s6_press", press, 4'b0111);
        for (int k = 1; k <= 11; k++) begin
            step();
            check("s6_repeat", press, (k == 8 || k == 11) ? 4'b0100 : 4'b0000);
        end

        // Scenario 5: inverted channel 3 idles low, pressing (pin low) sets level
        check("s5_idle", {3'b000, level[3]}, 4'b0000);
        raw_in[3] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("s5_level", {3'b000, level[3]}, {3'b000, (k == 6)});
        end
        check("s5_rise", {3'b000, rise[3]}, 4'b0001);

        // Scenario 4: tick every 4th clock; release of channel 3 needs 4 ticks
        raw_in[3] = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick = ((k % 4) == 0);
            step();
            check("s4_tick_level", {3'b000, level[3]}, {3'b000, (k < 16)});
            check("s4_tick_fall",  {3'b000, fall[3]},  {3'b000, (k == 16)});
        end
        tick = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
